common_pseudo_lru_tree_bin: RTL

Tree pseudo-LRU victim selector for set-associative structures. It is the decode-direction counterpart of the swap PLRU with encoded binary output: accesses arrive as binary way indices and are decoded internally, and the victim leaves as a one-hot vector. Way-valid tracking is built in, so invalid ways are always filled before any valid way is evicted. It sits beside cache and TLB tag arrays and drives the one-hot way write-enables directly.

---
 rtl/common_pseudo_lru_tree_bin.sv | 71 +++++++
 1 files changed

// File: rtl/common_pseudo_lru_tree_bin.sv
// Tree pseudo-LRU victim selector with binary touch/invalidate indices,
// built-in way-valid tracking and a one-hot victim output.
module common_pseudo_lru_tree_bin #(
    parameter int SUBJECT_COUNT_LOG2 = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [SUBJECT_COUNT_LOG2-1:0]       waddr,
    input  logic                                wen,
    input  logic [SUBJECT_COUNT_LOG2-1:0]       iaddr,
    input  logic                                ien,
    output logic [(1<<SUBJECT_COUNT_LOG2)-1:0]  qaddr,
    output logic                                qfull
);

    localparam int L = SUBJECT_COUNT_LOG2;
    localparam int P = 1 << L;

    logic [P-2:0] tree;
    logic [P-2:0] tree_d;
    logic [P-1:0] valid;
    logic [P-1:0] valid_d;
    logic [P-1:0] touch_oh;
    logic [P-1:0] inval_oh;
    logic [P-1:0] invalid;
    logic [P-1:0] free;
    logic [P-1:0] walk;
    logic [L-1:0] hit [P];

    // A node is on the touch path when the top l address bits select it
    // within its level; it then points at the half not holding waddr.
    for (genvar l = 0; l < L; l++) begin : g_lvl
        for (genvar k = 0; k < (1 << l); k++) begin : g_node
            localparam int NODE = (1 << l) - 1 + k;
            localparam logic [L-1:0] KV = L'(k);
            logic on_path;
            assign on_path = wen && ((waddr >> (L - l)) == KV);
            assign tree_d[NODE] = on_path ? ~waddr[L-1-l] : tree[NODE];
        end
    end

    assign touch_oh = wen ? (P'(1) << waddr) : '0;
    assign inval_oh = ien ? (P'(1) << iaddr) : '0;
    assign valid_d  = (valid | touch_oh) & ~inval_oh;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tree  <= '0;
            valid <= '0;
        end else begin
            tree  <= tree_d;
            valid <= valid_d;
        end
    end

    // Way w is the walk result iff every node on its path points toward it.
    for (genvar w = 0; w < P; w++) begin : g_way
        for (genvar l = 0; l < L; l++) begin : g_bit
            localparam int NODE = (1 << l) - 1 + (w >> (L - l));
            localparam logic WB = 1'((w >> (L - 1 - l)) & 1);
            assign hit[w][l] = (tree[NODE] == WB);
        end
        assign walk[w] = &hit[w];
    end

    assign invalid = ~valid;
    assign free    = invalid & (~invalid + P'(1));
    assign qfull   = &valid;
    assign qaddr   = qfull ? walk : free;

endmodule
